// File: rtl/hvtx_tmds_enc.sv
// hvtx_tmds_enc: one TMDS lane encoder (8b/10b video with running disparity, control codes), latency 2.
// Define HVTX_TERC4_EN to add TERC4 data-island coding selected by i_ade when i_de is low.
module hvtx_tmds_enc #(
   parameter bit OUT_INV = 1'b0
) (
   input  logic       i_pclk,
   input  logic       i_rst,
   input  logic       i_de,
   input  logic [1:0] i_c,
   input  logic [7:0] i_data,
   input  logic       i_ade,
   input  logic [3:0] i_aux,
   output logic [9:0] o_sym
);

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      MODE_CTRL  = 2'd0,
      MODE_VIDEO = 2'd1,
      MODE_AUX   = 2'd2
   } mode_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = CTRL_00;
         2'b01:   s = CTRL_01;
         2'b10:   s = CTRL_10;
         default: s = CTRL_11;
      endcase
      return s;
   endfunction

`ifdef HVTX_TERC4_EN
   function automatic logic [9:0] terc4_code(input logic [3:0] a);
      logic [9:0] s;
      case (a)
         4'h0:    s = 10'b1010011100;
         4'h1:    s = 10'b1001100011;
         4'h2:    s = 10'b1011100100;
         4'h3:    s = 10'b1011100010;
         4'h4:    s = 10'b0101110001;
         4'h5:    s = 10'b0100011110;
         4'h6:    s = 10'b0110001110;
         4'h7:    s = 10'b0100111100;
         4'h8:    s = 10'b1011001100;
         4'h9:    s = 10'b0100111001;
         4'hA:    s = 10'b0110011100;
         4'hB:    s = 10'b1011000111;
         4'hC:    s = 10'b1010001110;
         4'hD:    s = 10'b1001110001;
         4'hE:    s = 10'b0101100011;
         default: s = 10'b1011000011;
      endcase
      return s;
   endfunction
`else
   logic unused_aux;
   assign unused_aux = ^{i_ade, i_aux};
`endif

   // ---------------------------------------------------------------- stage 1
   mode_t      mode_nxt;
   logic [8:0] qm_nxt;
   logic [3:0] n1d;
   logic       use_xnor;
   logic       acc;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      mode_nxt = MODE_CTRL;
      if (i_de) mode_nxt = MODE_VIDEO;
`ifdef HVTX_TERC4_EN
      else if (i_ade) mode_nxt = MODE_AUX;
`endif

      n1d      = popcount8(i_data);
      use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !i_data[0]);
      acc      = i_data[0];
      qm_nxt   = '0;
      qm_nxt[0] = acc;
      for (int i = 1; i < 8; i++) begin
         acc = use_xnor ? ~(acc ^ i_data[i]) : (acc ^ i_data[i]);
         qm_nxt[i] = acc;
      end
      qm_nxt[8] = ~use_xnor;
   end

   mode_t      s1_mode;
   logic [1:0] s1_c;
   logic [8:0] s1_qm;
`ifdef HVTX_TERC4_EN
   logic [3:0] s1_aux;
`endif

   // NOTE: only control state is reset; q_m/aux are datapath and are ignored while the mode is control.
   always_ff @(posedge i_pclk) begin
      s1_qm <= qm_nxt;
`ifdef HVTX_TERC4_EN
      s1_aux <= i_aux;
`endif
      if (i_rst) begin
         s1_mode <= MODE_CTRL;
         s1_c    <= 2'b00;
      end else begin
         s1_mode <= mode_nxt;
         s1_c    <= i_c;
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [3:0]        n1;
   logic              q8;
   logic signed [4:0] diff;
   logic signed [4:0] cnt;
   logic signed [4:0] cnt_nxt;
   logic [9:0]        sym_nxt;
   logic [9:0]        sym_r;

   always_comb begin
      n1      = popcount8(s1_qm[7:0]);
      q8      = s1_qm[8];
      // diff = N1 - N0 = 2*N1 - 8, always within -8..+8
      diff    = $signed(({1'b0, n1} - 5'd4) << 1);
      cnt_nxt = '0;
      sym_nxt = CTRL_00;
      case (s1_mode)
         MODE_VIDEO: begin
            if (cnt == 5'sd0 || diff == 5'sd0) begin
               sym_nxt = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
               cnt_nxt = q8 ? cnt + diff : cnt - diff;
            end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
               sym_nxt = {1'b1, q8, ~s1_qm[7:0]};
               cnt_nxt = cnt - diff + (q8 ? 5'sd2 : 5'sd0);
            end else begin
               sym_nxt = {1'b0, q8, s1_qm[7:0]};
               cnt_nxt = cnt + diff - (q8 ? 5'sd0 : 5'sd2);
            end
         end
`ifdef HVTX_TERC4_EN
         MODE_AUX: begin
            sym_nxt = terc4_code(s1_aux);
            cnt_nxt = '0;
         end
`endif
         default: begin
            sym_nxt = ctrl_code(s1_c);
            cnt_nxt = '0;
         end
      endcase
   end

   // Reset loads control code 00 into both output stages so in-flight symbols are discarded.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         cnt   <= '0;
         sym_r <= CTRL_00;
         o_sym <= CTRL_00 ^ {10{OUT_INV}};
      end else begin
         cnt   <= cnt_nxt;
         sym_r <= sym_nxt;
         o_sym <= sym_r ^ {10{OUT_INV}};
      end
   end

endmodule

// File: tb/tb_hvtx_tmds_enc.sv
// Self-checking bench for hvtx_tmds_enc: directed spec scenarios plus randomized traffic
// compared every cycle against a behavioural model (integer disparity, symbol queue for latency).
module tb_hvtx_tmds_enc;

   localparam logic [9:0] RST_SYM = 10'b1101010100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       de = 1'b0;
   logic [1:0] c = 2'b00;
   logic [7:0] data = 8'h00;
   logic       ade = 1'b0;
   logic [3:0] aux = 4'h0;
   logic [9:0] sym;
   logic [9:0] sym_inv;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hvtx_tmds_enc #(.OUT_INV(1'b0)) dut (
      .i_pclk(clk), .i_rst(rst), .i_de(de), .i_c(c), .i_data(data),
      .i_ade(ade), .i_aux(aux), .o_sym(sym)
   );

   hvtx_tmds_enc #(.OUT_INV(1'b1)) dut_inv (
      .i_pclk(clk), .i_rst(rst), .i_de(de), .i_c(c), .i_data(data),
      .i_ade(ade), .i_aux(aux), .o_sym(sym_inv)
   );

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   int         m_cnt = 0;
   logic [9:0] m_pipe[$];
   logic [9:0] exp_out;
   bit         have_exp = 1'b0;
   logic [9:0] obs_hist[$];
   int         cur_idx;

   function automatic int pop8(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic logic [9:0] ctrl_ref(input logic [1:0] cc);
      case (cc)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

`ifdef HVTX_TERC4_EN
   function automatic logic [9:0] terc4_ref(input logic [3:0] a);
      logic [9:0] tbl [16];
      tbl = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
              10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
              10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
              10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
      return tbl[a];
   endfunction
`endif

   // Video symbol from the 8b/10b rules, with disparity kept as a plain integer.
   function automatic logic [9:0] video_ref(input logic [7:0] d, inout int cnt);
      logic [8:0] qm;
      logic [7:0] low;
      bit         xn;
      int         n1, n0;
      xn    = (pop8(d) > 4) || (pop8(d) == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      low   = qm[7:0];
      n1    = pop8(low);
      n0    = 8 - n1;
      if (cnt == 0 || n1 == n0) begin
         cnt += qm[8] ? (n1 - n0) : (n0 - n1);
         return {~qm[8], qm[8], qm[8] ? low : ~low};
      end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
         cnt += 2 * int'(qm[8]) + (n0 - n1);
         return {1'b1, qm[8], ~low};
      end else begin
         cnt += -2 * int'(!qm[8]) + (n1 - n0);
         return {1'b0, qm[8], low};
      end
   endfunction

   // One rising edge of the model: reset flushes everything in flight; output lags input by 2 edges.
   task automatic model_edge(input bit r, input bit d, input logic [1:0] cc,
                             input logic [7:0] dd, input bit a, input logic [3:0] x);
      logic [9:0] s;
      if (r) begin
         foreach (m_pipe[i]) m_pipe[i] = RST_SYM;
         m_cnt = 0;
         s = RST_SYM;
      end else if (d) begin
         s = video_ref(dd, m_cnt);
`ifdef HVTX_TERC4_EN
      end else if (a) begin
         s = terc4_ref(x);
         m_cnt = 0;
`endif
      end else begin
         s = ctrl_ref(cc);
         m_cnt = 0;
      end
      m_pipe.push_back(s);
      exp_out = m_pipe.pop_front();
   endtask

   // Check the previous edge's result, log it, then drive inputs for the next edge.
   task automatic step(input bit r, input bit d, input logic [1:0] cc,
                       input logic [7:0] dd, input bit a, input logic [3:0] x);
      @(negedge clk);
      if (have_exp) begin
         check("model", sym, exp_out);
         check("model_inv", sym_inv, ~exp_out);
      end
      cur_idx = obs_hist.size();
      obs_hist.push_back(sym);
      rst  = r;
      de   = d;
      c    = cc;
      data = dd;
      ade  = a;
      aux  = x;
      model_edge(r, d, cc, dd, a, x);
      have_exp = 1'b1;
   endtask

   task automatic ctl(input logic [1:0] cc, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, cc, 8'h00, 1'b0, 4'h0);
   endtask

   // Symbol sampled by the call at index idx is logged three calls later.
   task automatic lit(input string tag, input int idx, input logic [9:0] exp);
      if (idx + 3 < obs_hist.size()) check(tag, obs_hist[idx + 3], exp);
      else check({tag, "_missing"}, 10'bx, exp);
   endtask

   int a_idx, b_idx, e_idx, f_idx, g_idx, h_idx;
   bit r_de;

   initial begin
      m_pipe.push_back(RST_SYM);
      m_pipe.push_back(RST_SYM);

      // T1: held reset
      step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
      a_idx = cur_idx;
      step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
      step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
      ctl(2'b00, 2);
      check("t1_rst0", obs_hist[a_idx + 1], 10'b1101010100);
      check("t1_rst2", obs_hist[a_idx + 3], 10'b1101010100);
      step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
      check("t1_inv", sym_inv, 10'b0010101011);

      // T2: control codes
      ctl(2'b01, 1);
      b_idx = cur_idx;
      ctl(2'b01, 3);
      ctl(2'b11, 4);
      ctl(2'b00, 3);
      lit("t2_c01", b_idx, 10'b0010101011);
      lit("t2_c11", b_idx + 4, 10'b1010101011);
      lit("t2_c11_hold", b_idx + 7, 10'b1010101011);

      // T3: disparity walk with 0x00, then de 1->0
      ctl(2'b00, 2);
      step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0);
      e_idx = cur_idx;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0);
      ctl(2'b00, 4);
      lit("t3_s0", e_idx,     10'b0100000000);
      lit("t3_s1", e_idx + 1, 10'b1111111111);
      lit("t3_s2", e_idx + 2, 10'b0100000000);
      lit("t3_s3", e_idx + 3, 10'b1111111111);
      lit("t3_de_fall", e_idx + 4, 10'b1101010100);

      // T4: XNOR path from cnt=0
      step(1'b0, 1'b1, 2'b00, 8'hFF, 1'b0, 4'h0);
      f_idx = cur_idx;
      ctl(2'b10, 4);
      lit("t4_xnor", f_idx, 10'b1000000000);
      lit("t4_ctl10", f_idx + 1, 10'b0101010100);

      // T5: reset pulse mid-stream
      step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0);
      g_idx = cur_idx;
      step(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0);
      step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 4'h0);
      ctl(2'b00, 4);
      check("t5_rst", obs_hist[g_idx + 2], 10'b1101010100);
      check("t5_flush", obs_hist[g_idx + 3], 10'b1101010100);
      lit("t5_restart", g_idx + 2, 10'b0100000000);

      // T6: aux nibbles with i_c = 10 so the non-TERC4 build shows a distinct control code
      step(1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 4'h0);
      h_idx = cur_idx;
      step(1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 4'hF);
      ctl(2'b00, 4);
`ifdef HVTX_TERC4_EN
      lit("t6_terc0", h_idx,     10'b1010011100);
      lit("t6_tercF", h_idx + 1, 10'b1011000011);
`else
      lit("t6_noterc0", h_idx,     10'b0101010100);
      lit("t6_notercF", h_idx + 1, 10'b0101010100);
`endif

      // Randomized traffic: de bursts, aux islands, extreme pixels, occasional reset
      r_de = 1'b0;
      for (int n = 0; n < 6000; n++) begin
         logic [7:0] px;
         bit         rr;
         if ($urandom_range(0, 11) == 0) r_de = ~r_de;
         rr = ($urandom_range(0, 249) == 0);
         case ($urandom_range(0, 5))
            0:       px = 8'h00;
            1:       px = 8'hFF;
            default: px = 8'($urandom);
         endcase
         step(rr, r_de, 2'($urandom), px, ($urandom_range(0, 2) == 0), 4'($urandom));
      end
      ctl(2'b00, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
